// File: rtl/axi_b_rr_arbiter.sv
// Round-robin merge of NumInp AXI B-channel streams into one, with a two-entry registered spill stage.
// Define AXI_B_RR_ARBITER_BYPASS_EN to drop the stage for a zero-latency combinational path with a stall lock.
module axi_b_rr_arbiter #(
  parameter int NumInp    = 4,
  parameter int IdWidth   = 4,
  parameter int UserWidth = 1,
  localparam int W        = IdWidth + 2 + UserWidth,
  localparam int IdxW     = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumInp-1:0]     inp_valid_i,
  output logic [NumInp-1:0]     inp_ready_o,
  input  logic [NumInp*W-1:0]   inp_data_i,
  output logic                  oup_valid_o,
  input  logic                  oup_ready_i,
  output logic [W-1:0]          oup_data_o,
  output logic [IdxW-1:0]       oup_idx_o
);

  typedef logic [IdxW-1:0] idx_t;

  function automatic idx_t add_mod(idx_t base, int off);
    int s;
    s = int'(base) + off;
    if (s >= NumInp) s = s - NumInp;
    return idx_t'(s);
  endfunction

  logic [W-1:0] beats [NumInp];
  for (genvar i = 0; i < NumInp; i++) begin : g_unpack
    assign beats[i] = inp_data_i[i*W +: W];
  end

  idx_t         ptr_q, ptr_d;
  idx_t         rr_idx;
  logic         rr_found;
  idx_t         arb_idx;
  logic         arb_vld;
  logic         accept;
  logic         in_fire;
  logic [W-1:0] arb_beat;

  // Cyclic search starting at the priority pointer; first valid requester wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < NumInp; k++) begin
      idx_t cand;
      cand = add_mod(ptr_q, k);
      if (!rr_found && inp_valid_i[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign arb_beat = beats[arb_idx];
  assign in_fire  = rst_ni & arb_vld & accept;
  assign ptr_d    = in_fire ? add_mod(arb_idx, 1) : ptr_q;

  always_comb begin
    inp_ready_o = '0;
    if (in_fire) inp_ready_o[arb_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

`ifdef AXI_B_RR_ARBITER_BYPASS_EN

  logic lock_q;
  idx_t lock_idx_q;

  assign arb_idx = lock_q ? lock_idx_q : rr_idx;
  assign arb_vld = lock_q ? inp_valid_i[lock_idx_q] : rr_found;
  assign accept  = oup_ready_i;

  assign oup_valid_o = rst_ni & (|inp_valid_i);
  assign oup_data_o  = rst_ni ? arb_beat : '0;
  assign oup_idx_o   = rst_ni ? arb_idx  : '0;

  // A stalled beat pins the grant so the presented output cannot change under backpressure.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (oup_valid_o && oup_ready_i) begin
      lock_q     <= 1'b0;
    end else if (oup_valid_o && !lock_q) begin
      lock_q     <= 1'b1;
      lock_idx_q <= arb_idx;
    end
  end

`else

  logic         out_valid_q, skid_valid_q;
  logic [W-1:0] out_data_q,  skid_data_q;
  idx_t         out_idx_q,   skid_idx_q;
  logic         out_fire;

  assign arb_idx  = rr_idx;
  assign arb_vld  = rr_found;
  // Ready depends only on stored occupancy, never on oup_ready_i.
  assign accept   = ~skid_valid_q;
  assign out_fire = out_valid_q & oup_ready_i;

  assign oup_valid_o = rst_ni & out_valid_q;
  assign oup_data_o  = rst_ni ? out_data_q : '0;
  assign oup_idx_o   = rst_ni ? out_idx_q  : '0;

  // NOTE: the data registers are reset as well, because the output must read zero straight after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_idx_q   <= '0;
    end else if (!out_valid_q || out_fire) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        out_idx_q    <= skid_idx_q;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= in_fire;
        if (in_fire) begin
          out_data_q <= arb_beat;
          out_idx_q  <= arb_idx;
        end
      end
    end else if (in_fire) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= arb_beat;
      skid_idx_q   <= arb_idx;
    end
  end

`endif

endmodule

// File: tb/tb_axi_b_rr_arbiter.sv
// Directed + randomized scoreboard bench for axi_b_rr_arbiter (default spill-stage build).
module tb_axi_b_rr_arbiter;

  localparam int NumInp    = 4;
  localparam int IdWidth   = 4;
  localparam int UserWidth = 1;
  localparam int W         = IdWidth + 2 + UserWidth;
  localparam int IdxW      = 2;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [NumInp-1:0]   inp_valid_i;
  logic [NumInp-1:0]   inp_ready_o;
  logic [NumInp*W-1:0] inp_data_i;
  logic                oup_valid_o;
  logic                oup_ready_i;
  logic [W-1:0]        oup_data_o;
  logic [IdxW-1:0]     oup_idx_o;

  axi_b_rr_arbiter #(
    .NumInp    (NumInp),
    .IdWidth   (IdWidth),
    .UserWidth (UserWidth)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inp_valid_i (inp_valid_i),
    .inp_ready_o (inp_ready_o),
    .inp_data_i  (inp_data_i),
    .oup_valid_o (oup_valid_o),
    .oup_ready_i (oup_ready_i),
    .oup_data_o  (oup_data_o),
    .oup_idx_o   (oup_idx_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [IdxW-1:0] idx;
    logic [W-1:0]    data;
  } beat_t;

  int           n_cmp = 0;
  int           n_err = 0;
  beat_t        sb[$];
  int           m_ptr = 0;
  int           src_cnt [NumInp];
  logic [W-1:0] src_data[NumInp];
  logic [4:0]   seq = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(int ptr, logic [NumInp-1:0] v);
    for (int k = 0; k < NumInp; k++) begin
      int i;
      i = (ptr + k) % NumInp;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NumInp; i++) begin
      inp_valid_i[i]         = (src_cnt[i] > 0);
      inp_data_i[i*W +: W]   = src_data[i];
    end
  endtask

  // One clock: drive sources, compare against the model mid-cycle, then advance the model past the edge.
  task automatic step();
    logic [NumInp-1:0] exp_rdy;
    int                g;
    beat_t             b;
    drive();
    #1;
    exp_rdy = '0;
    g       = -1;
    if (rst_ni && sb.size() < 2) begin
      g = rr_pick(m_ptr, inp_valid_i);
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    check("inp_ready", 32'(inp_ready_o), 32'(exp_rdy));
    check("oup_valid", 32'(oup_valid_o), 32'(rst_ni && sb.size() > 0));
    if (rst_ni && sb.size() > 0) begin
      check("oup_idx",  32'(oup_idx_o),  32'(sb[0].idx));
      check("oup_data", 32'(oup_data_o), 32'(sb[0].data));
    end else if (!rst_ni) begin
      check("rst_idx",  32'(oup_idx_o),  32'd0);
      check("rst_data", 32'(oup_data_o), 32'd0);
    end
    if (!rst_ni) begin
      sb.delete();
      m_ptr = 0;
    end else begin
      if (sb.size() > 0 && oup_ready_i) void'(sb.pop_front());
      if (g >= 0) begin
        b.idx  = IdxW'(g);
        b.data = src_data[g];
        sb.push_back(b);
        m_ptr       = (g + 1) % NumInp;
        src_cnt[g]  = src_cnt[g] - 1;
        seq         = seq + 5'd1;
        src_data[g] = {2'(g), seq};
      end
    end
    @(negedge clk_i);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_ni      = 1'b0;
    oup_ready_i = 1'b0;
    inp_valid_i = '0;
    inp_data_i  = '0;
    for (int i = 0; i < NumInp; i++) begin
      src_cnt[i]  = 1;
      src_data[i] = W'(7'h10 + i);
    end
    @(negedge clk_i);
    // Reset with all inputs valid: everything must stay quiet.
    steps(2);
    for (int i = 0; i < NumInp; i++) src_cnt[i] = 0;
    rst_ni = 1'b1;
    steps(1);

    // Single requester 2, one-cycle latency.
    oup_ready_i = 1'b1;
    src_data[2] = 7'h2A;
    src_cnt[2]  = 1;
    steps(3);

    // Pointer now 3: requesters 0 and 1 contend, wrap to 0 first, then 1.
    src_cnt[0] = 2;
    src_cnt[1] = 1;
    steps(5);

    // Reset pointer, then all four valid continuously with full throughput.
    rst_ni = 1'b0;
    steps(1);
    rst_ni = 1'b1;
    for (int i = 0; i < NumInp; i++) src_cnt[i] = 8;
    steps(36);

    // Backpressure: two beats fill the stage, then inputs see no ready.
    oup_ready_i = 1'b0;
    src_cnt[0]  = 3;
    src_cnt[1]  = 3;
    steps(5);
    oup_ready_i = 1'b1;
    steps(10);

    // Reset with two beats stored; they must vanish and arbitration restarts at 0.
    oup_ready_i = 1'b0;
    src_cnt[0]  = 1;
    src_cnt[1]  = 1;
    steps(3);
    rst_ni = 1'b0;
    steps(1);
    rst_ni      = 1'b1;
    oup_ready_i = 1'b1;
    src_cnt[1]  = 1;
    src_cnt[3]  = 1;
    steps(5);

    // Random sources and backpressure.
    for (int n = 0; n < 300; n++) begin
      oup_ready_i = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NumInp; i++)
        if (src_cnt[i] == 0 && $urandom_range(0, 3) == 0) src_cnt[i] = $urandom_range(1, 3);
      step();
    end

    for (int i = 0; i < NumInp; i++) src_cnt[i] = 0;
    oup_ready_i = 1'b1;
    steps(4);
    check("drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_b_rr_arbiter.md
AXI_B_RR_ARBITER -- requirements
Module: axi_b_rr_arbiter

Interface
REQ-001 SHALL have parameter NumInp, default 4, number of B-channel requesters (range 2..16).
REQ-002 SHALL have parameter IdWidth, default 4, B-channel ID width.
REQ-003 SHALL have parameter UserWidth, default 1, B-channel user width; beat width W = IdWidth+2+UserWidth, packed {id, resp[1:0], user}.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port inp_valid_i  input  NumInp  per-requester beat valid.
REQ-007 SHALL have port inp_ready_o  output  NumInp  per-requester ready; at most one bit high per cycle.
REQ-008 SHALL have port inp_data_i  input  NumInp*W  requester i beat at bits [i*W +: W].
REQ-009 SHALL have port oup_valid_o  output  1  merged beat valid.
REQ-010 SHALL have port oup_ready_i  input  1  downstream ready.
REQ-011 SHALL have port oup_data_o  output  W  merged beat.
REQ-012 SHALL have port oup_idx_o  output  max(1,$clog2(NumInp))  index of the requester that supplied oup_data_o.

Function
REQ-013 SHALL grant the lowest index i with inp_valid_i[i]=1, searching cyclically from priority pointer P (i=P, P+1, ..., wrapping NumInp-1 to 0).
REQ-014 SHALL assert inp_ready_o[g] only for the granted index g, and only when the output stage can accept a beat; all other ready bits SHALL be 0.
REQ-015 SHALL treat input handshake as inp_valid_i[g] & inp_ready_o[g]; on handshake P SHALL become (g+1) mod NumInp; otherwise P SHALL hold.
REQ-016 SHALL assert no inp_ready_o bit when no inp_valid_i bit is set.
REQ-017 SHALL, with default build, use a two-entry output spill stage: beats leave in acceptance order, oup_data_o/oup_idx_o driven from registers only.
REQ-018 SHALL present an accepted beat on oup_valid_o exactly one cycle after its input handshake when the stage was empty.
REQ-019 SHALL accept a new input beat whenever the spill stage holds fewer than 2 beats, or holds 2 beats and oup_ready_i=1 is not required (ready to inputs SHALL NOT depend combinationally on oup_ready_i).
REQ-020 SHALL sustain one beat per cycle when oup_ready_i stays high and any input is valid.
REQ-021 SHALL hold oup_valid_o, oup_data_o and oup_idx_o stable while oup_valid_o=1 and oup_ready_i=0.
REQ-022 SHALL, with stage full and oup_ready_i=0, deassert all inp_ready_o; simultaneous input and output handshake with one beat stored SHALL leave one beat stored (new beat).
REQ-023 SHALL pass data unmodified: no reordering within a requester, no beat dropped or duplicated.

Reset
REQ-024 SHALL, when rst_ni=0 at a rising edge, empty the spill stage and set P=0, regardless of in-flight beats (beats in the stage are discarded).
REQ-025 SHALL drive during and after reset oup_valid_o=0, oup_data_o=0, oup_idx_o=0, inp_ready_o=0 while rst_ni=0.
REQ-026 SHALL resume arbitration from P=0 on the first cycle after rst_ni returns to 1.

Configuration
REQ-027 SHALL, when macro AXI_B_RR_ARBITER_BYPASS_EN is defined, remove the spill stage: oup_valid_o = OR of inp_valid_i, oup_data_o/oup_idx_o muxed combinationally from grant, inp_ready_o[g] = oup_ready_i, latency 0.
REQ-028 SHALL, with AXI_B_RR_ARBITER_BYPASS_EN defined, lock grant g (P and search frozen) from the first cycle oup_valid_o=1 with oup_ready_i=0 until the output handshake, so REQ-021 holds.
REQ-029 SHALL, without AXI_B_RR_ARBITER_BYPASS_EN, implement REQ-017..REQ-022 and contain no combinational path from inp_* to oup_* or from oup_ready_i to inp_ready_o.

Verification
REQ-030 SHALL cover: NumInp=4, all inputs valid continuously, oup_ready_i=1 -> grants 0,1,2,3,0,... one per cycle, oup_idx_o same sequence one cycle later.
REQ-031 SHALL cover: only input 2 valid with data 0x2A, stage empty -> inp_ready_o=4'b0100 cycle 0, oup_valid_o=1 with oup_data_o=0x2A, oup_idx_o=2 cycle 1.
REQ-032 SHALL cover: oup_ready_i=0 for 5 cycles with inputs 0,1 valid -> exactly 2 beats accepted (idx 0 then 1), inp_ready_o=0 afterward, output stable; release -> beats out in order 0,1.
REQ-033 SHALL cover: P=3, inputs 0 and 1 valid -> grant 0 (wrap-around), P becomes 1.
REQ-034 SHALL cover: rst_ni=0 for one cycle with 2 beats stored -> next cycle oup_valid_o=0, P=0, stored beats never appear.
REQ-035 SHALL cover: BYPASS_EN build, input 1 valid, oup_ready_i=0 three cycles while input 0 raises valid -> oup_idx_o stays 1, data stable, input 1 handshakes when oup_ready_i=1.
